// File: rtl/instr_byte_loader_if.sv
// Word handshake between the byte loader (master) and the core (slave).
interface instr_byte_loader_if;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;

    modport master (output word_out, output word_valid, input  word_ready);
    modport slave  (input  word_out, input  word_valid, output word_ready);
endinterface

// File: rtl/instr_byte_loader.sv
// Pin-bus byte loader: synchronizes a host strobe, assembles bytes
// little-endian into 32-bit words, buffers them in a FIFO and presents
// them to the core over a valid/ready handshake.
module instr_byte_loader #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_in,
    input  logic                     byte_stb,
    input  logic                     clr,
    instr_byte_loader_if.master      wb,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [1:0]               byte_idx,
    output logic                     overflow,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    // Last idle count before expiry; unused when the timeout is disabled.
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    logic [2:0]  sync_q;
    logic        capture;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] part_q, part_d;
    logic [15:0] idle_q, idle_d;
    logic        terr_q, terr_d;
    logic        push_req, push, pop, full, empty;
    logic        ovf_q;
    logic [AW:0] wptr_q, rptr_q;
    logic [31:0] mem_q [DEPTH];

    // Two-flop synchronizer plus an edge-detect flop on the host strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   sync_q <= '0;
        else if (clr) sync_q <= '0;
        else          sync_q <= {sync_q[1:0], byte_stb};
    end

    assign capture = sync_q[1] & ~sync_q[2];

    // Byte assembly and idle timeout; a capture always beats expiry.
    always_comb begin
        idx_d    = idx_q;
        part_d   = part_q;
        idle_d   = idle_q;
        terr_d   = terr_q;
        push_req = 1'b0;
        if (capture) begin
            idle_d = '0;
            idx_d  = idx_q + 2'd1;
            case (idx_q)
                2'd0:    part_d[7:0]   = byte_in;
                2'd1:    part_d[15:8]  = byte_in;
                2'd2:    part_d[23:16] = byte_in;
                default: push_req      = 1'b1;
            endcase
        end else if (idx_q != 2'd0 && TIMEOUT != 0) begin
            if (idle_q == TO_LAST) begin
                idx_d  = '0;
                part_d = '0;
                idle_d = '0;
                terr_d = 1'b1;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end else begin
            idle_d = '0;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            part_q <= '0;
            idle_q <= '0;
            terr_q <= 1'b0;
        end else if (clr) begin
            idx_q  <= '0;
            part_q <= '0;
            idle_q <= '0;
            terr_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            part_q <= part_d;
            idle_q <= idle_d;
            terr_q <= terr_d;
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && wb.word_ready;
    // A full FIFO still takes the word if the head leaves this same cycle.
    assign push  = push_req && (!full || pop);

    // FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push_req && !push) ovf_q <= 1'b1;
        end
    end

    // Storage needs no reset: word_out is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wptr_q[AW-1:0]] <= {byte_in, part_q};
    end

    assign wb.word_valid = !empty;
    assign wb.word_out   = empty ? 32'd0 : mem_q[rptr_q[AW-1:0]];
    assign fifo_count    = wptr_q - rptr_q;
    assign byte_idx      = idx_q;
    assign overflow      = ovf_q;
    assign timeout_err   = terr_q;
endmodule

// File: tb/tb_instr_byte_loader.sv
// Self-checking bench for instr_byte_loader against a queue-based model.
module tb_instr_byte_loader;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_stb = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] fifo_count;
    logic [1:0] byte_idx;
    logic       overflow, timeout_err;

    instr_byte_loader_if wif();

    instr_byte_loader #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_stb(byte_stb), .clr(clr),
        .wb(wif.master), .fifo_count(fifo_count), .byte_idx(byte_idx),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words held, bytes of the partial word, sticky flags.
    logic [31:0] mq[$];
    logic [7:0]  m_part[$];
    bit          m_ovf, m_terr;

    function automatic void m_clear();
        mq.delete(); m_part.delete(); m_ovf = 0; m_terr = 0;
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        logic [31:0] w;
        m_part.push_back(b);
        if (m_part.size() == 4) begin
            w = {m_part[3], m_part[2], m_part[1], m_part[0]};
            m_part.delete();
            if (mq.size() < DEPTH) mq.push_back(w);
            else m_ovf = 1;
        end
    endfunction

    // One strobe: 4 cycles high, 4 low. With rdy_cap, word_ready is high only
    // on the edge where the byte is captured (3rd edge after the rise).
    task automatic send_byte(input logic [7:0] b, input bit rdy_cap);
        @(posedge clk); #1 byte_in = b; byte_stb = 1'b1;
        if (rdy_cap) begin
            repeat (2) @(posedge clk);
            #1 wif.word_ready = 1'b1;
            @(posedge clk); #1 wif.word_ready = 1'b0;
            @(posedge clk);
        end else begin
            repeat (4) @(posedge clk);
        end
        #1 byte_stb = 1'b0;
        repeat (4) @(posedge clk);
        m_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy_last);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rdy_last && i == 3);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        m_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wif.word_ready = 1'b0;
        m_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
        checks++; if (wif.word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", wif.word_valid); end
        checks++; if (wif.word_out !== 32'd0) begin errors++; $display("FAIL rst_word got %h exp 0", wif.word_out); end
        checks++; if (byte_idx !== 2'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", byte_idx); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_terr got %b exp 0", timeout_err); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        // First byte by hand to observe the 3-edge capture latency.
        @(posedge clk); #1 byte_in = 8'h13; byte_stb = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (byte_idx !== 2'd0) begin errors++; $display("FAIL lat_pre got %0d exp 0", byte_idx); end
        @(posedge clk); @(negedge clk);
        checks++; if (byte_idx !== 2'd1) begin errors++; $display("FAIL lat_cap got %0d exp 1", byte_idx); end
        @(posedge clk); #1 byte_stb = 1'b0;
        repeat (4) @(posedge clk);
        m_byte(8'h13);
        send_byte(8'h05, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        @(negedge clk);
        checks++; if (wif.word_valid !== 1'b1) begin errors++; $display("FAIL sw_valid got %b exp 1", wif.word_valid); end
        checks++; if (wif.word_out !== mq[0] || mq[0] !== 32'h00100513) begin errors++; $display("FAIL sw_word got %h exp %h", wif.word_out, 32'h00100513); end
        checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL sw_count got %0d exp %0d", fifo_count, mq.size()); end
        checks++; if (byte_idx !== 2'(m_part.size())) begin errors++; $display("FAIL sw_idx got %0d exp %0d", byte_idx, m_part.size()); end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] exp;
        pulse_clr();
        for (int i = 1; i <= 5; i++) send_word(32'h11111111 * i, 0);
        @(negedge clk);
        checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL fill_count got %0d exp %0d", fifo_count, mq.size()); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL fill_ovf got %b exp %b", overflow, m_ovf); end
        @(posedge clk); #1 wif.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = mq.pop_front();
            checks++; if (wif.word_valid !== 1'b1 || wif.word_out !== exp) begin errors++; $display("FAIL drain_%0d got %h/%b exp %h/1", i, wif.word_out, wif.word_valid, exp); end
            @(posedge clk);
        end
        #1 wif.word_ready = 1'b0;
        @(negedge clk);
        checks++; if (wif.word_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", wif.word_valid); end
    endtask

    task automatic test_concurrent();
        logic [31:0] w, exp;
        pulse_clr();
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        w = $urandom;
        for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8], 0);
        void'(mq.pop_front());  // the head leaves on the completing edge
        send_byte(w[31:24], 1);
        @(negedge clk);
        checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL cc_count got %0d exp %0d", fifo_count, mq.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL cc_ovf got %b exp 0", overflow); end
        @(posedge clk); #1 wif.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = mq.pop_front();
            checks++; if (wif.word_out !== exp) begin errors++; $display("FAIL cc_drain_%0d got %h exp %h", i, wif.word_out, exp); end
            @(posedge clk);
        end
        #1 wif.word_ready = 1'b0;
    endtask

    task automatic test_timeout();
        pulse_clr();
        send_byte($urandom, 0); send_byte($urandom, 0);
        // send_byte returns 5 edges after the capture edge.
        repeat (TO - 1 - 5) @(posedge clk);
        @(negedge clk);
        checks++; if (byte_idx !== 2'd2 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_pre got idx %0d terr %b exp 2/0", byte_idx, timeout_err); end
        @(posedge clk); @(negedge clk);
        m_part.delete(); m_terr = 1;
        checks++; if (byte_idx !== 2'd0 || timeout_err !== m_terr) begin errors++; $display("FAIL to_fire got idx %0d terr %b exp 0/1", byte_idx, timeout_err); end
        repeat (4) @(posedge clk);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
        @(negedge clk);
        checks++; if (wif.word_out !== mq[0] || mq[0] !== 32'hDDCCBBAA) begin errors++; $display("FAIL to_word got %h exp ddccbbaa", wif.word_out); end
        checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL to_count got %0d exp %0d", fifo_count, mq.size()); end
    endtask

    task automatic test_clear_reset();
        logic [31:0] w;
        w = $urandom;
        send_word(w, 0);
        for (int i = 0; i < 3; i++) send_byte($urandom, 0);
        @(negedge clk);
        checks++; if (fifo_count !== 3'(mq.size()) || byte_idx !== 2'(m_part.size()) || timeout_err !== m_terr) begin errors++; $display("FAIL clr_pre got cnt %0d idx %0d terr %b exp %0d/%0d/%b", fifo_count, byte_idx, timeout_err, mq.size(), m_part.size(), m_terr); end
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); @(negedge clk);
        m_clear();
        checks++; if (fifo_count !== 3'd0 || byte_idx !== 2'd0 || wif.word_valid !== 1'b0) begin errors++; $display("FAIL clr_state got cnt %0d idx %0d valid %b exp 0/0/0", fifo_count, byte_idx, wif.word_valid); end
        checks++; if (timeout_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL clr_flags got terr %b ovf %b exp 0/0", timeout_err, overflow); end
        @(posedge clk); #1 clr = 1'b0;
        send_word($urandom, 0);
        send_byte($urandom, 0); send_byte($urandom, 0);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        m_clear();
        checks++; if (fifo_count !== 3'd0 || byte_idx !== 2'd0 || wif.word_valid !== 1'b0 || wif.word_out !== 32'd0) begin errors++; $display("FAIL async_rst got cnt %0d idx %0d valid %b word %h exp all 0", fifo_count, byte_idx, wif.word_valid, wif.word_out); end
        checks++; if (overflow !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL async_rst_flags got %b/%b exp 0/0", overflow, timeout_err); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        logic [31:0] exp[$];
        logic [31:0] got[$];
        bit done = 0;
        int n = 0;
        for (int i = 0; i < 10; i++) exp.push_back($urandom);
        fork
            begin
                for (int i = 0; i < 10; i++) send_word(exp[i], 0);
                done = 1;
            end
            begin
                while (!(done && !wif.word_valid) && n < 3000) begin
                    @(posedge clk); #1 wif.word_ready = ~wif.word_ready;
                    @(negedge clk);
                    if (wif.word_valid && wif.word_ready) got.push_back(wif.word_out);
                    n++;
                end
            end
        join
        @(posedge clk); #1 wif.word_ready = 1'b0;
        checks++; if (n >= 3000) begin errors++; $display("FAIL wrap_timeout got %0d cycles exp < 3000", n); end
        checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_len got %0d exp 10", got.size()); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= got.size()) begin errors++; $display("FAIL wrap_word_%0d got none exp %h", i, exp[i]); end
            else if (got[i] !== exp[i]) begin errors++; $display("FAIL wrap_word_%0d got %h exp %h", i, got[i], exp[i]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b exp 0", overflow); end
    endtask

    initial begin
        wif.word_ready = 1'b0;
        test_reset();
        test_single_word();
        test_fill_overflow();
        test_concurrent();
        test_timeout();
        test_clear_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_byte_loader.md
Name: instr_byte_loader

Overview:
- Sits between the tile's 8-bit dedicated input pins and the processor core.
- Captures bytes presented on the pin bus under a host-driven strobe and assembles them little-endian into 32-bit words.
- Buffers completed words in a small FIFO and hands them to the core over a valid/ready handshake.
- Gives the core a way to receive instructions and data despite the narrow pad interface.

Parameters:
- DEPTH, 4: FIFO depth in 32-bit words; must be a power of 2, minimum 2.
- TIMEOUT, 1024: idle cycles after which a partial word is discarded. 0 disables the timeout. Maximum value 65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- byte_in  input  8  data byte from the pins; host holds it stable from strobe rise until strobe fall
- byte_stb  input  1  host strobe, asynchronous to clk; each rising edge delivers one byte
- clr  input  1  synchronous clear, active-high, already synchronous to clk
- word_out  output  32  FIFO head word
- word_valid  output  1  FIFO not empty
- word_ready  input  1  core accepts word_out this cycle
- fifo_count  output  $clog2(DEPTH)+1  number of words held
- byte_idx  output  2  bytes held in the current partial word
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full
- timeout_err  output  1  sticky: a partial word was discarded by the timeout

Behaviour:
- **Reset** (rst_n low, asynchronous) clears everything:
  - FIFO empty; fifo_count=0, word_valid=0, word_out=0.
  - byte_idx=0, overflow=0, timeout_err=0.
  - Synchronizer flops and the idle counter cleared.
  - Reset mid-word discards the partial word.
- **Strobe synchronizer:**
  - byte_stb passes through a 2-flop synchronizer, then a third flop for rising-edge detect.
  - A capture pulse lasts one cycle.
  - byte_in is sampled in the capture-pulse cycle.
  - Pin rise to capture is 3 clk edges.
  - Falling edges are ignored.
- **Assembler** (counter states B0..B3 = byte_idx):
  - A capture in Bk writes byte_in to bits [8k+7:8k] and advances to B(k+1).
  - A capture in B3 completes the word, attempts a FIFO push the same cycle, and returns to B0.
- **FIFO push:**
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - When full with no pop, the word is dropped and overflow is set. Assembly still returns to B0.
- **FIFO pop:** occurs when word_valid && word_ready.
  - word_out always shows the head. It is combinational from the registered storage; no extra latency.
  - A word pushed at edge N is visible with word_valid=1 after edge N.
- **Simultaneous push and pop:**
  - fifo_count is unchanged.
  - When the FIFO held exactly one word, the new word becomes the head after the edge.
- **Pointers:** read and write pointers are log2(DEPTH)+1 bits. Full means MSBs differ and LSBs are equal. Wrap-around is seamless.
- **Timeout:**
  - An idle counter runs only while byte_idx≠0 and is reset by every capture.
  - When it reaches TIMEOUT, byte_idx returns to 0, the partial data is discarded, and timeout_err is set.
  - A capture in the same cycle as expiry wins: the byte is accepted and the counter resets.
  - With TIMEOUT=0 the counter never expires.
- **clr:**
  - Same effect as reset, except it is synchronous.
  - clr has priority over a capture or pop in the same cycle.
- word_out content is don't-care when word_valid=0 (reset value 0).

Test Plan:
- **Single word:** strobe bytes 0x13,0x05,0x10,0x00 with word_ready=0 → word_valid=1, word_out=0x00100513, fifo_count=1, byte_idx=0; the first capture occurs 3 cycles after the first pin rise.
- **Fill and overflow:** push 5 words (0x11111111..0x55555555), ready=0 → fifo_count=4, overflow=1. Then drain with ready=1 → outputs 0x11111111..0x44444444 in order, word_valid=0 after the 4th pop.
- **Concurrent push/pop:** hold ready=1 with the FIFO full and complete a word → accepted, overflow stays 0, count stays 4.
- **Timeout:** TIMEOUT=16, send 2 bytes then idle 20 cycles → byte_idx returns to 0 at the 16th idle cycle, timeout_err=1. Four further bytes 0xAA,0xBB,0xCC,0xDD → word_out=0xDDCCBBAA.
- **Clear and reset:** assert clr with byte_idx=3 and fifo_count=2 → the next cycle shows count=0, byte_idx=0, sticky flags cleared. Then pulse rst_n low mid-word asynchronously → all outputs 0 without a clock edge.
- **Wrap-around:** stream 10 words with ready toggling every other cycle → all 10 words are received in order, with no loss and no duplication.
